// File: rtl/dac_axi_writer.sv
// Buffers an 8-bit sample stream and writes it to memory as AXI4 write bursts.
// Define DAC_WR_TIMEOUT_EN to add a write-response timeout.
module dac_axi_writer #(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       BURST_LEN = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic [7:0]        axi_awlen,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [7:0]        axi_wdata,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    output logic              axi_wlast,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    output logic              busy,
    output logic              error
);

    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam int unsigned IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {StFill, StBurst, StResp} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              frame_end_q, frame_end_d;
    logic              awvalid_q, awvalid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [7:0]        awlen_q, awlen_d;
    logic              wvalid_q, wvalid_d;
    logic [7:0]        beat_q, beat_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              error_q, error_d;
    logic              tready_q, tready_d;
    logic [7:0]        mem_q [BURST_LEN];
`ifdef DAC_WR_TIMEOUT_EN
    logic [7:0]        tmo_q, tmo_d;
`endif

    logic s_hs, aw_hs, w_hs, wlast, resp_done;

    assign s_hs  = (state_q == StFill) && s_axis_tvalid && tready_q;
    assign aw_hs = awvalid_q && axi_awready;
    assign w_hs  = wvalid_q && axi_wready;
    assign wlast = wvalid_q && (beat_q == awlen_q);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cur_addr_d  = cur_addr_q;
        frame_end_d = frame_end_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        wvalid_d    = wvalid_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        error_d     = error_q;
        resp_done   = 1'b0;
`ifdef DAC_WR_TIMEOUT_EN
        tmo_d       = '0;
`endif
        case (state_q)
            StFill: begin
                if (s_hs) begin
                    count_d = count_q + 1'b1;
                    if ((count_d == CW'(BURST_LEN)) || s_axis_tlast) begin
                        // AW and first W beat are offered together.
                        state_d     = StBurst;
                        frame_end_d = s_axis_tlast;
                        awvalid_d   = 1'b1;
                        wvalid_d    = 1'b1;
                        awaddr_d    = cur_addr_q;
                        awlen_d     = 8'(count_q);
                        beat_d      = '0;
                        aw_done_d   = 1'b0;
                        w_done_d    = 1'b0;
                    end
                end
            end
            StBurst: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (wlast) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast))) begin
                    state_d = StResp;
                end
            end
            StResp: begin
`ifdef DAC_WR_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
`endif
                if (axi_bvalid) begin
                    resp_done = 1'b1;
                    if (axi_bresp != 2'b00) error_d = 1'b1;
`ifdef DAC_WR_TIMEOUT_EN
                end else if (tmo_q == 8'd254) begin
                    resp_done = 1'b1;
                    error_d   = 1'b1;
`endif
                end
                if (resp_done) begin
                    state_d    = StFill;
                    count_d    = '0;
                    cur_addr_d = frame_end_q ? BASE_ADDR
                                             : cur_addr_q + ADDR_W'(awlen_q) + ADDR_W'(1);
                end
            end
            default: state_d = StFill;
        endcase
        tready_d = (state_d == StFill) && (count_d < CW'(BURST_LEN));
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q     <= StFill;
            count_q     <= '0;
            cur_addr_q  <= BASE_ADDR;
            frame_end_q <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= BASE_ADDR;
            awlen_q     <= '0;
            wvalid_q    <= 1'b0;
            beat_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            error_q     <= 1'b0;
            tready_q    <= 1'b0;
`ifdef DAC_WR_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cur_addr_q  <= cur_addr_d;
            frame_end_q <= frame_end_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            wvalid_q    <= wvalid_d;
            beat_q      <= beat_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            error_q     <= error_d;
            tready_q    <= tready_d;
`ifdef DAC_WR_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Sample storage needs no reset; count_q alone marks valid entries.
    always_ff @(posedge axi_aclk) begin
        if (!axi_areset && s_hs) begin
            mem_q[count_q[IW-1:0]] <= s_axis_tdata;
        end
    end

    assign s_axis_tready = tready_q;
    assign axi_awaddr    = awaddr_q;
    assign axi_awlen     = awlen_q;
    assign axi_awvalid   = awvalid_q;
    assign axi_wvalid    = wvalid_q;
    assign axi_wlast     = wlast;
    assign axi_wdata     = wvalid_q ? mem_q[beat_q[IW-1:0]] : 8'h00;
    assign axi_bready    = (state_q == StResp);
    assign busy          = (state_q != StFill) || (count_q != '0);
    assign error         = error_q;

endmodule

// File: tb/tb_dac_axi_writer.sv
// Directed bench for dac_axi_writer with BURST_LEN=4, BASE_ADDR=0.
// Each table row streams one frame and checks the resulting AXI bursts beat by beat.
module tb_dac_axi_writer;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        axi_areset;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [7:0]  s_axis_tdata;
    logic [15:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic        axi_awvalid, axi_awready;
    logic [7:0]  axi_wdata;
    logic        axi_wvalid, axi_wready, axi_wlast;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid, axi_bready;
    logic        busy, error;

    dac_axi_writer #(
        .ADDR_W   (16),
        .BURST_LEN(BL),
        .BASE_ADDR(16'h0000)
    ) dut (
        .axi_aclk     (clk),
        .axi_areset   (axi_areset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .axi_awaddr   (axi_awaddr),
        .axi_awlen    (axi_awlen),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_wlast    (axi_wlast),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  first;
        int          nbytes;
        bit          last;
        int          aw_delay;
        bit          w_alt;
        logic [1:0]  bresp;
        logic [15:0] addr0;
        bit          exp_err;
    } row_t;

    typedef struct packed {logic [7:0] d; logic l;} beat_t;
    typedef struct packed {logic [15:0] a; logic [7:0] len;} aw_t;

    row_t       rows[8];
    beat_t      sq[$];
    beat_t      exp_w[$];
    aw_t        exp_aw[$];
    logic [1:0] bresp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int aw_idx, w_idx, b_cnt, aw_cnt, aw_delay;
    bit w_alt, w_tog, b_hold, awv_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, then check and log the
    // handshakes that the next rising edge will take.
    task automatic tick();
        @(negedge clk);
        s_axis_tvalid = (sq.size() > 0);
        s_axis_tdata  = (sq.size() > 0) ? sq[0].d : 8'h00;
        s_axis_tlast  = (sq.size() > 0) ? sq[0].l : 1'b0;
        axi_awready   = axi_awvalid && (aw_cnt >= aw_delay);
        w_tog         = w_alt ? ~w_tog : 1'b1;
        axi_wready    = w_tog;
        axi_bvalid    = axi_bready && !b_hold && (bresp_q.size() > 0);
        axi_bresp     = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
        #1;
        if (axi_awvalid || axi_wvalid || axi_bready) begin
            check("tready_blocked", 32'(s_axis_tready), 32'd0);
            check("busy_active", 32'(busy), 32'd1);
        end
        if (axi_awvalid && !awv_prev) check("w_with_aw", 32'(axi_wvalid), 32'd1);
        if (axi_awvalid) begin
            check("aw_in_range", 32'(aw_idx < exp_aw.size()), 32'd1);
            if (aw_idx < exp_aw.size()) begin
                check("awaddr", 32'(axi_awaddr), 32'(exp_aw[aw_idx].a));
                check("awlen", 32'(axi_awlen), 32'(exp_aw[aw_idx].len));
            end
        end
        if (axi_wvalid) begin
            check("w_in_range", 32'(w_idx < exp_w.size()), 32'd1);
            if (w_idx < exp_w.size()) begin
                check("wdata", 32'(axi_wdata), 32'(exp_w[w_idx].d));
                check("wlast", 32'(axi_wlast), 32'(exp_w[w_idx].l));
            end
        end
        if (s_axis_tvalid && s_axis_tready) sq.delete(0);
        if (axi_awvalid && axi_awready) begin
            aw_idx++;
            aw_cnt = 0;
        end else if (axi_awvalid) begin
            aw_cnt++;
        end
        if (axi_wvalid && axi_wready) w_idx++;
        if (axi_bvalid && axi_bready) begin
            bresp_q.delete(0);
            b_cnt++;
        end
        awv_prev = axi_awvalid;
    endtask

    task automatic setup(input row_t r);
        int          rem;
        int          idx;
        int          len;
        logic [15:0] a;
        sq.delete();
        exp_w.delete();
        exp_aw.delete();
        bresp_q.delete();
        aw_idx   = 0;
        w_idx    = 0;
        b_cnt    = 0;
        aw_cnt   = 0;
        aw_delay = r.aw_delay;
        w_alt    = r.w_alt;
        w_tog    = 1'b0;
        for (int i = 0; i < r.nbytes; i++) begin
            sq.push_back('{d: r.first + 8'(i), l: (r.last && (i == r.nbytes - 1))});
        end
        a   = r.addr0;
        rem = r.nbytes;
        idx = 0;
        while (rem > 0) begin
            len = (rem > BL) ? BL : rem;
            exp_aw.push_back('{a: a, len: 8'(len - 1)});
            for (int j = 0; j < len; j++) begin
                exp_w.push_back('{d: r.first + 8'(idx + j), l: (j == len - 1)});
            end
            bresp_q.push_back((exp_aw.size() == 1) ? r.bresp : 2'b00);
            idx += len;
            rem -= len;
            a   += 16'(len);
        end
    endtask

    task automatic run_row(input row_t r);
        int nb;
        setup(r);
        nb = exp_aw.size();
        for (int t = 0; t < 300 && !(b_cnt == nb && sq.size() == 0); t++) tick();
        check("row_done", 32'(b_cnt), 32'(nb));
        check("aw_total", 32'(aw_idx), 32'(nb));
        check("w_total", 32'(w_idx), 32'(exp_w.size()));
        tick();
        check("error", 32'(error), 32'(r.exp_err));
        check("busy_idle", 32'(busy), 32'd0);
        check("tready_idle", 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        int n;
        rows[0] = '{8'h10, 8, 1'b1, 0, 1'b0, 2'b00, 16'h0000, 1'b0};
        rows[1] = '{8'hA0, 3, 1'b1, 0, 1'b0, 2'b00, 16'h0000, 1'b0};
        rows[2] = '{8'h20, 5, 1'b1, 0, 1'b0, 2'b00, 16'h0000, 1'b0};
        rows[3] = '{8'h30, 4, 1'b1, 5, 1'b1, 2'b00, 16'h0000, 1'b0};
        rows[4] = '{8'h40, 4, 1'b0, 6, 1'b0, 2'b00, 16'h0000, 1'b0};
        rows[5] = '{8'h50, 2, 1'b1, 0, 1'b1, 2'b00, 16'h0004, 1'b0};
        rows[6] = '{8'h60, 8, 1'b1, 0, 1'b0, 2'b10, 16'h0000, 1'b1};
        rows[7] = '{8'h70, 2, 1'b1, 0, 1'b0, 2'b00, 16'h0000, 1'b1};

        axi_areset    = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        axi_awready   = 1'b0;
        axi_wready    = 1'b0;
        axi_bvalid    = 1'b0;
        axi_bresp     = 2'b00;
        b_hold        = 1'b0;
        awv_prev      = 1'b0;
        aw_delay      = 0;
        w_alt         = 1'b0;
        aw_cnt        = 0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_awvalid", 32'(axi_awvalid), 32'd0);
        check("rst_wvalid", 32'(axi_wvalid), 32'd0);
        check("rst_wlast", 32'(axi_wlast), 32'd0);
        check("rst_bready", 32'(axi_bready), 32'd0);
        check("rst_awaddr", 32'(axi_awaddr), 32'h0000);
        check("rst_awlen", 32'(axi_awlen), 32'd0);
        check("rst_wdata", 32'(axi_wdata), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        axi_areset = 1'b0;
        check("tready_at_release", 32'(s_axis_tready), 32'd0);
        tick();
        check("tready_rise", 32'(s_axis_tready), 32'd1);

        for (int i = 0; i < 8; i++) run_row(rows[i]);

        // Reset pulsed while W beat 2 of a burst is on the bus.
        setup('{8'h80, 8, 1'b1, 0, 1'b0, 2'b00, 16'h0000, 1'b0});
        for (int t = 0; t < 50 && w_idx < 1; t++) tick();
        check("reached_beat2", 32'(w_idx), 32'd1);
        @(negedge clk);
        axi_areset    = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_awvalid", 32'(axi_awvalid), 32'd0);
        check("midrst_wvalid", 32'(axi_wvalid), 32'd0);
        check("midrst_bready", 32'(axi_bready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        axi_areset = 1'b0;
        awv_prev   = 1'b0;
        run_row('{8'h90, 4, 1'b1, 0, 1'b0, 2'b00, 16'h0000, 1'b0});

`ifdef DAC_WR_TIMEOUT_EN
        setup('{8'hB0, 1, 1'b1, 0, 1'b0, 2'b00, 16'h0000, 1'b0});
        b_hold = 1'b1;
        for (int t = 0; t < 50 && !axi_bready; t++) tick();
        check("resp_entered", 32'(axi_bready), 32'd1);
        n = 1;
        for (int t = 0; t < 400; t++) begin
            tick();
            if (!axi_bready) break;
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd255);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_fill", 32'(s_axis_tready), 32'd1);
        b_hold = 1'b0;
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
